// File: rtl/multicycle_controller_if.sv
// Instruction-field / control-strobe bundle between the datapath side (master)
// and the multicycle controller (slave).
interface multicycle_controller_if;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic        mem_ready;

   logic        ir_en;
   logic        pc_en;
   logic        reg_wr;
   logic        sel_A;
   logic        sel_B;
   logic [1:0]  wb_sel;
   logic [2:0]  ImmSrc;
   logic [3:0]  alu_op;
   logic [2:0]  br_type;
   logic [2:0]  ReadControl;
   logic [2:0]  WriteControl;
   logic        halted;
   logic [31:0] instret;

   modport master (
      output opcode, funct3, funct7, mem_ready,
      input  ir_en, pc_en, reg_wr, sel_A, sel_B, wb_sel, ImmSrc, alu_op,
             br_type, ReadControl, WriteControl, halted, instret
   );

   modport slave (
      input  opcode, funct3, funct7, mem_ready,
      output ir_en, pc_en, reg_wr, sel_A, sel_B, wb_sel, ImmSrc, alu_op,
             br_type, ReadControl, WriteControl, halted, instret
   );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32I main controller: FETCH/DECODE/EXEC/MEM/WB sequencing,
// datapath selects, memory access controls and a retired-instruction counter.
module multicycle_controller (
   input  logic                   clk,
   input  logic                   rst,
   multicycle_controller_if.slave bus
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_e;

   typedef enum logic [3:0] {
      C_RALU    = 4'd0,
      C_IALU    = 4'd1,
      C_LUI     = 4'd2,
      C_AUIPC   = 4'd3,
      C_LOAD    = 4'd4,
      C_STORE   = 4'd5,
      C_BRANCH  = 4'd6,
      C_JAL     = 4'd7,
      C_JALR    = 4'd8,
      C_ILLEGAL = 4'd9
   } class_e;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_SLL   = 4'd2;
   localparam logic [3:0] ALU_SLT   = 4'd3;
   localparam logic [3:0] ALU_SLTU  = 4'd4;
   localparam logic [3:0] ALU_XOR   = 4'd5;
   localparam logic [3:0] ALU_SRL   = 4'd6;
   localparam logic [3:0] ALU_SRA   = 4'd7;
   localparam logic [3:0] ALU_OR    = 4'd8;
   localparam logic [3:0] ALU_AND   = 4'd9;
   localparam logic [3:0] ALU_PASSB = 4'd10;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_U = 3'd3;
   localparam logic [2:0] IMM_J = 3'd4;

   localparam logic [1:0] WB_PC4 = 2'd0;
   localparam logic [1:0] WB_ALU = 2'd1;
   localparam logic [1:0] WB_MEM = 2'd2;

   localparam logic [2:0] BR_ALWAYS = 3'd7;

   state_e      state_q, state_d;
   class_e      cls_q, cls_d;
   logic [2:0]  f3_q;
   logic        f7b5_q;
   logic        run_q;
   logic [31:0] instret_q;

   logic        ir_en;
   logic        pc_en;
   logic        reg_wr;
   logic        sel_a;
   logic        sel_b;
   logic [1:0]  wb_sel;
   logic [2:0]  imm_src;
   logic [3:0]  alu_op;
   logic [2:0]  br_type;
   logic [2:0]  read_ctl;
   logic [2:0]  write_ctl;

   logic        f7_legal;
   logic        is_shift;

   // SUB exists only for R-type; SRA/SRAI both key off funct7[5] with funct3 = 101.
   function automatic logic [3:0] alu_from_funct(input logic [2:0] f3,
                                                 input logic       f7b5,
                                                 input logic       is_r);
      logic [3:0] op;
      case (f3)
         3'b000:  op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   function automatic logic [2:0] br_from_f3(input logic [2:0] f3);
      logic [2:0] br;
      case (f3)
         3'b000:  br = 3'd1;
         3'b001:  br = 3'd2;
         3'b100:  br = 3'd3;
         3'b101:  br = 3'd4;
         3'b110:  br = 3'd5;
         3'b111:  br = 3'd6;
         default: br = 3'd0;
      endcase
      return br;
   endfunction

   function automatic logic [2:0] rd_from_f3(input logic [2:0] f3);
      logic [2:0] rd;
      case (f3)
         3'b000:  rd = 3'd1;
         3'b001:  rd = 3'd2;
         3'b010:  rd = 3'd3;
         3'b100:  rd = 3'd4;
         3'b101:  rd = 3'd5;
         default: rd = 3'd0;
      endcase
      return rd;
   endfunction

   function automatic logic [2:0] wr_from_f3(input logic [2:0] f3);
      logic [2:0] wr;
      case (f3)
         3'b000:  wr = 3'd1;
         3'b001:  wr = 3'd2;
         3'b010:  wr = 3'd3;
         default: wr = 3'd0;
      endcase
      return wr;
   endfunction

   assign f7_legal = (bus.funct7 == 7'b0000000) || (bus.funct7 == 7'b0100000);
   assign is_shift = (bus.funct3[1:0] == 2'b01);

   // Classify the live instruction register fields; only consumed in DECODE.
   always_comb begin
      cls_d = C_ILLEGAL;
      case (bus.opcode)
         OP_R:      if (f7_legal) cls_d = C_RALU;
         OP_I:      if (f7_legal || !is_shift) cls_d = C_IALU;
         OP_LOAD:   if (bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) cls_d = C_LOAD;
         OP_STORE:  if (bus.funct3 inside {3'b000, 3'b001, 3'b010}) cls_d = C_STORE;
         OP_BRANCH: if (bus.funct3[2:1] != 2'b01) cls_d = C_BRANCH;
         OP_JAL:    cls_d = C_JAL;
         OP_JALR:   cls_d = C_JALR;
         OP_LUI:    cls_d = C_LUI;
         OP_AUIPC:  cls_d = C_AUIPC;
         default:   cls_d = C_ILLEGAL;
      endcase
   end

   // run_q keeps every output quiet until the first edge after reset release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_FETCH;
         cls_q     <= C_RALU;
         f3_q      <= 3'd0;
         f7b5_q    <= 1'b0;
         run_q     <= 1'b0;
         instret_q <= 32'd0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q <= state_d;
         run_q   <= 1'b1;
         if (state_q == S_DECODE) begin
            cls_q  <= cls_d;
            f3_q   <= bus.funct3;
            f7b5_q <= bus.funct7[5];
         end
         if (pc_en) instret_q <= instret_q + 32'd1;
      end
   end

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      state_d   = state_q;
      ir_en     = 1'b0;
      pc_en     = 1'b0;
      reg_wr    = 1'b0;
      sel_a     = 1'b0;
      sel_b     = 1'b0;
      wb_sel    = WB_PC4;
      imm_src   = IMM_I;
      alu_op    = ALU_ADD;
      br_type   = 3'd0;
      read_ctl  = 3'd0;
      write_ctl = 3'd0;

      // ALU operand selects stay driven from EXEC through WB of the latched instruction.
      if (state_q inside {S_EXEC, S_MEM, S_WB}) begin
         case (cls_q)
            C_RALU: begin
               sel_a  = 1'b1;
               alu_op = alu_from_funct(f3_q, f7b5_q, 1'b1);
            end
            C_IALU: begin
               sel_a  = 1'b1;
               sel_b  = 1'b1;
               alu_op = alu_from_funct(f3_q, f7b5_q, 1'b0);
            end
            C_LUI: begin
               sel_b   = 1'b1;
               imm_src = IMM_U;
               alu_op  = ALU_PASSB;
            end
            C_AUIPC: begin
               sel_b   = 1'b1;
               imm_src = IMM_U;
            end
            C_LOAD, C_JALR: begin
               sel_a = 1'b1;
               sel_b = 1'b1;
            end
            C_STORE: begin
               sel_a   = 1'b1;
               sel_b   = 1'b1;
               imm_src = IMM_S;
            end
            C_BRANCH: begin
               sel_b   = 1'b1;
               imm_src = IMM_B;
            end
            C_JAL: begin
               sel_b   = 1'b1;
               imm_src = IMM_J;
            end
            default: ;
         endcase
      end

      case (state_q)
         S_FETCH: begin
            if (run_q) begin
               ir_en   = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: state_d = (cls_d == C_ILLEGAL) ? S_HALT : S_EXEC;
         S_EXEC: begin
            case (cls_q)
               C_BRANCH: begin
                  br_type = br_from_f3(f3_q);
                  pc_en   = 1'b1;
                  state_d = S_FETCH;
               end
               C_LOAD, C_STORE: state_d = S_MEM;
               default:         state_d = S_WB;
            endcase
         end
         S_MEM: begin
            if (cls_q == C_STORE) write_ctl = wr_from_f3(f3_q);
            else                  read_ctl  = rd_from_f3(f3_q);
            if (bus.mem_ready) begin
               if (cls_q == C_STORE) begin
                  pc_en   = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            reg_wr  = 1'b1;
            pc_en   = 1'b1;
            state_d = S_FETCH;
            case (cls_q)
               C_LOAD:        wb_sel = WB_MEM;
               C_JAL, C_JALR: begin
                  wb_sel  = WB_PC4;
                  br_type = BR_ALWAYS;
               end
               default:       wb_sel = WB_ALU;
            endcase
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_HALT;
      endcase
   end

   assign bus.ir_en        = ir_en;
   assign bus.pc_en        = pc_en;
   assign bus.reg_wr       = reg_wr;
   assign bus.sel_A        = sel_a;
   assign bus.sel_B        = sel_b;
   assign bus.wb_sel       = wb_sel;
   assign bus.ImmSrc       = imm_src;
   assign bus.alu_op       = alu_op;
   assign bus.br_type      = br_type;
   assign bus.ReadControl  = read_ctl;
   assign bus.WriteControl = write_ctl;
   assign bus.halted       = (state_q == S_HALT);
   assign bus.instret      = instret_q;

endmodule
